// File: rtl/axils_rd_ch.sv
// rtl/axils_rd_ch.sv - AXI4-Lite slave read channel decoding AR beats onto a word-indexed register-file read port
module axils_rd_ch #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       NUM_REGS  = 16,
  parameter int unsigned       TIMEOUT   = 16,
  localparam int unsigned      IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [2:0]        ARPROT,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              reg_rd_en,
  output logic [IDX_W-1:0]  reg_rd_addr,
  input  logic [31:0]       reg_rd_data,
  input  logic              reg_rd_valid,
  input  logic              reg_rd_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(4 * NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOCAL_WAIT = 2'd1,
    RESP       = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         rresp_q, rresp_d;
  logic               rd_en_q, rd_en_d;
  logic [IDX_W-1:0]   rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // One extra bit on the range compare so a window at the top of the map cannot wrap.
  logic [ADDR_W:0]    addr_ext;
  logic               in_range;
  logic [ADDR_W-1:0]  offset;
  logic               unused_bits;

  assign addr_ext    = {1'b0, ARADDR};
  assign in_range    = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
  assign offset      = ARADDR - BASE_ADDR;
  assign unused_bits = ^{ARPROT, offset};

  assign ARREADY     = (state_q == IDLE) && !ARESET;
  assign RVALID      = rvalid_q;
  assign RDATA       = rdata_q;
  assign RRESP       = rresp_q;
  assign reg_rd_en   = rd_en_q;
  assign reg_rd_addr = rd_addr_q;

  always_comb begin
    state_d   = state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ARVALID) begin
          if (!in_range) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_DECERR;
            state_d  = RESP;
          end else if (ARADDR[1:0] != 2'b00) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            state_d  = RESP;
          end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = offset[IDX_W+1:2];
            cnt_d     = '0;
            state_d   = LOCAL_WAIT;
          end
        end
      end
      LOCAL_WAIT: begin
        // Data arriving in the last allowed cycle still beats the timeout.
        if (reg_rd_valid) begin
          rvalid_d = 1'b1;
          rdata_d  = reg_rd_data;
          rresp_d  = reg_rd_err ? RESP_SLVERR : RESP_OKAY;
          state_d  = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          rvalid_d = 1'b1;
          rdata_d  = '0;
          rresp_d  = RESP_SLVERR;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (RREADY) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
